sample_feeder: RTL and testbench
================================

Name: sample_feeder

Overview:
- Producer on the far end of the CPU's `Din`/`Sample` input port.
- Buffers signed 8-bit samples written by a host/test source into a small FIFO.
- Presents them one at a time on `Din`, with a single-cycle `Sample` strobe at a programmable rate.
- Rate tick is shared in style with the CPU's slow-clock divider; `Turbo` bypasses the divider.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- CNT_MAX, 12500000, rate-divider terminal count; a rate tick fires when the divider equals 0.
- SETUP, 2, cycles `Din` is held stable before `Sample` asserts; at least 1.

Ports:
- Clock  in  1  single system clock; all logic on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- Wdata  in  8  sample to enqueue (signed).
- Wvalid  in  1  host write request.
- Wready  out  1  FIFO not full; a write happens when Wvalid && Wready.
- Turbo  in  1  asynchronous switch; when 1, a rate tick fires every cycle.
- Enable  in  1  when 0, no new sample transfer starts.
- Din  out  8  sample presented to the CPU.
- Sample  out  1  one-cycle strobe; Din is valid and stable while high.
- Level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- Underflow  out  1  sticky; set when a tick finds the FIFO empty while Enable=1.

Behaviour:
- Reset values: Din=0, Sample=0, Level=0, Underflow=0, Wready=1, divider=0, state=IDLE, FIFO pointers=0.
- Reset mid-transfer aborts the transfer; the FIFO is flushed.
- Turbo passes through a 2-flop synchroniser before use; it takes effect 2 cycles after it changes.
- Divider counts 0..CNT_MAX then wraps to 0. tick = (divider==0) || turbo_sync.
- FIFO: circular buffer, DEPTH entries, with pointer-wrap handling.
  - Write when Wvalid && Wready.
  - A pop happens only in the LOAD state.
  - Simultaneous push and pop when full is impossible, because pop is in LOAD and Wready reflects the pre-pop level. Level is unchanged on a simultaneous push+pop.
  - Writes while full are ignored; Wready=0 holds the host off.
- FSM:
  - IDLE: if tick && Enable && Level!=0 -> LOAD. If tick && Enable && Level==0 -> set Underflow, stay IDLE.
  - LOAD: Din <= FIFO head, pop, setup counter = SETUP-1 -> SETUP.
  - SETUP: decrement the counter; at 0 -> STROBE.
  - STROBE: Sample=1 for exactly this cycle; Din unchanged -> HOLD.
  - HOLD: one cycle with Din unchanged -> IDLE.
- Ticks arriving outside IDLE are dropped, not queued.
- Din keeps its last value in IDLE; it never changes from SETUP through HOLD.
- Latency from an accepted tick in IDLE to Sample high: SETUP+1 cycles.
- Minimum spacing between strobes in Turbo: SETUP+3 cycles.
- Enable dropping mid-transfer does not abort it; it only blocks the next LOAD.
- Underflow clears only on Reset.
- Sample is registered, not combinational.

Optional Feature:
- Macro: SAMPLE_FEEDER_REPEAT_EN.
- Defined: on a tick in IDLE with an empty FIFO and Enable=1, the FSM still runs LOAD..HOLD and re-presents the last Din (0 after reset) with a Sample strobe. There is no pop, and Underflow is still set.
- Undefined: an empty tick produces no strobe; only Underflow is set.

Decomposition:
- Shared package/header (alongside CPU.vh): FSM state encodings (IDLE, LOAD, SETUP, STROBE, HOLD) and the default CNT_MAX.
- One natural sub-module, `sample_fifo`: DEPTH-parameterised synchronous FIFO exposing push, pop, head data, level, full and empty.
- Reuse the existing Synchroniser for Turbo.

Test Plan:
- Reset, then write 0x05, 0x80, 0x7F with Turbo=1, Enable=1:
  - Sample pulses three times, one cycle each, spaced SETUP+3=5 cycles.
  - Din reads 0x05, 0x80, 0x7F at each strobe.
  - Level goes 3->0.
- CNT_MAX=9, Turbo=0, write 0x11:
  - Sample fires SETUP+1=3 cycles after the next divider==0.
  - With the FIFO empty, Underflow=1 at the following tick.
- Fill with 16 writes:
  - Wready=0 and Level=16.
  - A 17th write of 0xAA is dropped; the drained sequence contains no 0xAA.
- Write 0x33, Turbo=1, pulse Reset during SETUP:
  - No Sample.
  - Din=0, Level=0, state IDLE.
- SAMPLE_FEEDER_REPEAT_EN defined, write 0x42, Turbo=1:
  - Sample repeats with Din=0x42 indefinitely.
  - Underflow=1 from the second tick; Level stays 0.
  - Without the macro: a single strobe, then none.

Source files
------------

// File: rtl/sample_feeder_pkg.sv
// rtl/sample_feeder_pkg.sv - shared types, FSM encodings and defaults for the sample feeder
package sample_feeder_pkg;

    localparam int DEPTH_DEFAULT   = 16;
    localparam int CNT_MAX_DEFAULT = 12500000;
    localparam int SETUP_DEFAULT   = 2;

    typedef logic signed [7:0] sample_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_HOLD   = 3'd4
    } state_e;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int width_of(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sample_feeder_if.sv
// rtl/sample_feeder_if.sv - host write handshake into the sample feeder
interface sample_feeder_if;
    import sample_feeder_pkg::*;

    sample_t Wdata;
    logic    Wvalid;
    logic    Wready;

    modport master (output Wdata, output Wvalid, input Wready);
    modport slave  (input Wdata, input Wvalid, output Wready);

endinterface

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - power-of-two circular FIFO of samples with wrap-bit pointers
module sample_fifo
    import sample_feeder_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  sample_t                wdata,
    output sample_t                head,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    sample_t     mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push;
    logic        do_pop;

    // The extra MSB distinguishes full from empty when the index bits match.
    always_comb begin
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty    = (wr_ptr_q == rd_ptr_q);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

    assign level = wr_ptr_q - rd_ptr_q;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/synchroniser.sv
// rtl/synchroniser.sv - multi-flop synchroniser for a single asynchronous level
module synchroniser #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/sample_feeder.sv
// rtl/sample_feeder.sv - paced Din/Sample producer; SAMPLE_FEEDER_REPEAT_EN replays last Din on empty ticks
module sample_feeder
    import sample_feeder_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEFAULT,
    parameter int CNT_MAX = CNT_MAX_DEFAULT,
    parameter int SETUP   = SETUP_DEFAULT
) (
    input  logic                   Clock,
    input  logic                   Reset,
    sample_feeder_if.slave         wr,
    input  logic                   Turbo,
    input  logic                   Enable,
    output sample_t                Din,
    output logic                   Sample,
    output logic [$clog2(DEPTH):0] Level,
    output logic                   Underflow
);

    localparam int                 DIV_W      = width_of(CNT_MAX);
    localparam logic [DIV_W-1:0]   DIV_TOP    = DIV_W'(CNT_MAX);
    localparam int                 CNT_W      = width_of(SETUP);
    localparam logic [CNT_W-1:0]   SETUP_LOAD = CNT_W'(SETUP - 1);

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    sample_t             din_q, din_d;
    logic                sample_q, sample_d;
    logic                underflow_q, underflow_d;
    logic                replay_q, replay_d;

    logic                turbo_sync;
    logic                tick;
    logic                push;
    logic                pop;
    sample_t             fifo_head;
    logic                fifo_full;
    logic                fifo_empty;

    synchroniser #(.STAGES(2)) u_turbo_sync (
        .clk (Clock),
        .rst (Reset),
        .d   (Turbo),
        .q   (turbo_sync)
    );

    sample_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (Clock),
        .rst   (Reset),
        .push  (push),
        .pop   (pop),
        .wdata (wr.Wdata),
        .head  (fifo_head),
        .level (Level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign push      = wr.Wvalid && !fifo_full;
    assign wr.Wready = !fifo_full;

    always_comb begin
        div_d = (div_q == DIV_TOP) ? '0 : div_q + DIV_W'(1);
    end

    assign tick = (div_q == '0) || turbo_sync;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            cnt_q       <= '0;
            din_q       <= '0;
            sample_q    <= 1'b0;
            underflow_q <= 1'b0;
            replay_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            din_q       <= din_d;
            sample_q    <= sample_d;
            underflow_q <= underflow_d;
            replay_q    <= replay_d;
        end
    end

    // SETUP lasts SETUP-1 cycles so LOAD..STROBE spans SETUP+1 cycles after the tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (tick && Enable) begin
`ifdef SAMPLE_FEEDER_REPEAT_EN
                    state_d = ST_LOAD;
`else
                    if (!fifo_empty) state_d = ST_LOAD;
`endif
                end
            end
            ST_LOAD:   state_d = (SETUP > 1) ? ST_SETUP : ST_STROBE;
            ST_SETUP:  if (cnt_q <= CNT_W'(1)) state_d = ST_STROBE;
            ST_STROBE: state_d = ST_HOLD;
            ST_HOLD:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        din_d       = din_q;
        cnt_d       = cnt_q;
        underflow_d = underflow_q;
        replay_d    = replay_q;
        pop         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick && Enable && fifo_empty) underflow_d = 1'b1;
`ifdef SAMPLE_FEEDER_REPEAT_EN
                if (tick && Enable) replay_d = fifo_empty;
`else
                replay_d = 1'b0;
`endif
            end
            ST_LOAD: begin
                cnt_d = SETUP_LOAD;
                // A replayed transfer keeps Din and must not consume a late write.
                if (!replay_q) begin
                    din_d = fifo_head;
                    pop   = 1'b1;
                end
            end
            ST_SETUP: cnt_d = cnt_q - CNT_W'(1);
            default: ;
        endcase
        sample_d = (state_d == ST_STROBE);
    end

    assign Din       = din_q;
    assign Sample    = sample_q;
    assign Underflow = underflow_q;

endmodule

// File: tb/tb_sample_feeder.sv
// tb/tb_sample_feeder.sv - directed self-checking bench for sample_feeder
module tb_sample_feeder;

    localparam int DEPTH   = 16;
    localparam int CNT_MAX = 9;
    localparam int SETUP   = 2;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Turbo;
    logic       Enable;
    logic [7:0] din_w;
    logic       Sample;
    logic [4:0] Level;
    logic       Underflow;

    int         checks = 0;
    int         errors = 0;
    int         rel    = 0;
    int         s_cyc[$];
    logic [7:0] s_din[$];

    sample_feeder_if wr_if ();

    sample_feeder #(
        .DEPTH   (DEPTH),
        .CNT_MAX (CNT_MAX),
        .SETUP   (SETUP)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .wr        (wr_if),
        .Turbo     (Turbo),
        .Enable    (Enable),
        .Din       (din_w),
        .Sample    (Sample),
        .Level     (Level),
        .Underflow (Underflow)
    );

    always #5 Clock = ~Clock;

    always @(negedge Clock) begin
        if (Sample === 1'b1) begin
            s_cyc.push_back(rel);
            s_din.push_back(din_w);
        end
    end

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
        rel++;
    endtask

    task automatic run_to(input int c);
        while (rel < c) step();
    endtask

    task automatic clear_log();
        s_cyc.delete();
        s_din.delete();
    endtask

    task automatic reset_dut();
        Reset        = 1'b1;
        wr_if.Wvalid = 1'b0;
        wr_if.Wdata  = '0;
        step();
        step();
        Reset = 1'b0;
        rel   = 0;
        clear_log();
    endtask

    task automatic write(input logic [7:0] v);
        wr_if.Wvalid = 1'b1;
        wr_if.Wdata  = v;
        step();
        wr_if.Wvalid = 1'b0;
    endtask

    function automatic int sc(input int i);
        return (i < s_cyc.size()) ? s_cyc[i] : -1;
    endfunction

    function automatic int sd(input int i);
        return (i < s_din.size()) ? int'(s_din[i]) : -1;
    endfunction

    initial begin
        int t1_exp[3];
        t1_exp = '{8'h05, 8'h80, 8'h7F};
        Turbo  = 1'b0;
        Enable = 1'b0;

        // reset state, then three samples paced by Turbo
        reset_dut();
        check("rst_din", din_w, 0);
        check("rst_sample", Sample, 0);
        check("rst_level", Level, 0);
        check("rst_underflow", Underflow, 0);
        check("rst_wready", wr_if.Wready, 1);
        Turbo = 1'b1;
        write(8'h05);
        write(8'h80);
        write(8'h7F);
        check("t1_level3", Level, 3);
        Enable = 1'b1;
        run_to(30);
`ifndef SAMPLE_FEEDER_REPEAT_EN
        check("t1_count", s_cyc.size(), 3);
`endif
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t1_cyc%0d", i), sc(i), 6 + 5 * i);
            check($sformatf("t1_din%0d", i), sd(i), t1_exp[i]);
        end
        check("t1_level0", Level, 0);
        check("t1_underflow", Underflow, 1);

        // divider pacing with Turbo off
        Turbo  = 1'b0;
        Enable = 1'b0;
        reset_dut();
        write(8'h11);
        check("t2_level1", Level, 1);
        Enable = 1'b1;
        for (int c = 2; c <= 24; c++) begin
            int exp_s;
            run_to(c);
            exp_s = (c == 13) ? 1 : 0;
`ifdef SAMPLE_FEEDER_REPEAT_EN
            if (c == 23) exp_s = 1;
`endif
            check($sformatf("t2_sample@%0d", c), Sample, exp_s);
            if (c == 13) check("t2_din", din_w, 8'h11);
            if (c == 20) check("t2_underflow_pre", Underflow, 0);
            if (c == 21) check("t2_underflow_post", Underflow, 1);
        end

        // fill to full, drop the overflow write, drain in order
        Enable = 1'b0;
        Turbo  = 1'b1;
        reset_dut();
        for (int i = 0; i < 16; i++) write(8'(8'h10 + i));
        check("t3_wready", wr_if.Wready, 0);
        check("t3_level_full", Level, 16);
        write(8'hAA);
        check("t3_level_after_drop", Level, 16);
        clear_log();
        Enable = 1'b1;
        run_to(110);
`ifndef SAMPLE_FEEDER_REPEAT_EN
        check("t3_count", s_cyc.size(), 16);
`endif
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t3_din%0d", i), sd(i), 8'h10 + i);
        end
        check("t3_first_cyc", sc(0), 20);
        check("t3_last_cyc", sc(15), 95);

        // reset during SETUP aborts the transfer
        Enable = 1'b0;
        Turbo  = 1'b1;
        reset_dut();
        write(8'h33);
        run_to(3);
        clear_log();
        Enable = 1'b1;
        run_to(5);
        check("t4_din_setup", din_w, 8'h33);
        Reset  = 1'b1;
        Enable = 1'b0;
        Turbo  = 1'b0;
        step();
        Reset = 1'b0;
        run_to(14);
        check("t4_no_sample", s_cyc.size(), 0);
        check("t4_din", din_w, 0);
        check("t4_level", Level, 0);
        check("t4_underflow", Underflow, 0);
        check("t4_wready", wr_if.Wready, 1);

        // single sample followed by empty ticks
        Enable = 1'b0;
        Turbo  = 1'b1;
        reset_dut();
        write(8'h42);
        run_to(3);
        clear_log();
        Enable = 1'b1;
        run_to(8);
        check("t5_underflow_pre", Underflow, 0);
        run_to(9);
        check("t5_underflow_post", Underflow, 1);
        run_to(43);
`ifdef SAMPLE_FEEDER_REPEAT_EN
        check("t5_count", s_cyc.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t5_din%0d", i), sd(i), 8'h42);
        end
`else
        check("t5_count", s_cyc.size(), 1);
        check("t5_din0", sd(0), 8'h42);
`endif
        check("t5_cyc0", sc(0), 6);
        check("t5_level", Level, 0);
        check("t5_underflow_end", Underflow, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
